// File: rtl/dmux4way_dispatch_if.sv
// dmux4way_dispatch_if: producer-side valid/ready handshake, the four-channel
// consumer side, the DMux4Way select, flush and busy status for the dispatcher.
interface dmux4way_dispatch_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       sel;
    logic             flush;
    logic             busy;

    // Environment side: producer, consumers and flush control
    modport master (
        output in_valid, in_data, out_ready, flush,
        input  in_ready, out_valid, out_data, sel, busy
    );

    // Dispatcher side
    modport slave (
        input  in_valid, in_data, out_ready, flush,
        output in_ready, out_valid, out_data, sel, busy
    );
endinterface

// File: rtl/dmux4way_dispatch.sv
// dmux4way_dispatch: one-entry round-robin dispatcher in front of a DMux4Way.
// Holds one word and steers it to one of four channels through sel; out_valid
// is the held valid bit demuxed by sel. in_ready is the only combinational
// output. Optional macro DISPATCH_SKIP_EN: at load time the target skips
// ahead to the first ready channel in rotation order (falls back to the
// rotation pointer when none is ready).
module dmux4way_dispatch #(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 reset,
    dmux4way_dispatch_if.slave  bus
);
    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_data;

    logic             w_full;
    logic             w_deliver;
    logic             w_in_ready;
    logic             w_accept;
    logic [1:0]       w_base;
    logic [1:0]       w_target;

    assign w_full     = (r_state == ST_FULL);
    assign w_deliver  = w_full & bus.out_ready[r_sel];
    assign w_in_ready = ~reset & ~bus.flush & (~w_full | w_deliver);
    assign w_accept   = bus.in_valid & w_in_ready;

    // Target channel for a word loaded this cycle; the rotation base is the
    // channel after the one being delivered when back-to-back, else ptr
`ifdef DISPATCH_SKIP_EN
    logic       w_found;
    logic [1:0] w_idx;

    always_comb begin
        w_base   = w_full ? (r_sel + 2'd1) : r_ptr;
        w_target = w_base;
        w_found  = 1'b0;
        w_idx    = w_base;
        for (int unsigned k = 0; k < 4; k++) begin
            w_idx = w_base + 2'(k);
            if (!w_found && bus.out_ready[w_idx]) begin
                w_target = w_idx;
                w_found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        w_base   = w_full ? (r_sel + 2'd1) : r_ptr;
        w_target = w_base;
    end
`endif

    // Dispatcher FSM: one-entry holding register, target select and rotation pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_data  <= '0;
        end else if (bus.flush) begin
            // A delivery coinciding with flush still counts toward rotation
            r_state <= ST_EMPTY;
            if (w_deliver) begin
                r_ptr <= r_sel + 2'd1;
            end
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                        r_data  <= bus.in_data;
                        r_sel   <= w_target;
                    end
                end
                ST_FULL: begin
                    if (w_deliver) begin
                        r_ptr <= r_sel + 2'd1;
                        if (w_accept) begin
                            r_data <= bus.in_data;
                            r_sel  <= w_target;
                        end else begin
                            r_state <= ST_EMPTY;
                        end
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_full;
    assign bus.sel       = r_sel;
    assign bus.out_data  = r_data;
    assign bus.out_valid = w_full ? (4'b0001 << r_sel) : 4'b0000;
endmodule

// File: tb/tb_dmux4way_dispatch.sv
// tb_dmux4way_dispatch: table-driven rotation vectors plus hand-written
// sequences for reset, backpressure, flush, skip targeting and mid-run reset.
// Every delivery is checked against a scoreboard queue filled when words are
// accepted.
module tb_dmux4way_dispatch;
    localparam int WIDTH = 16;

`ifdef DISPATCH_SKIP_EN
    localparam logic [1:0] SKIP_CH = 2'd3;
`else
    localparam logic [1:0] SKIP_CH = 2'd1;
`endif

    logic clk;
    logic reset;

    dmux4way_dispatch_if #(.WIDTH(WIDTH)) bus ();

    dmux4way_dispatch #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] d;
        logic [3:0]       ordy;
        logic             exp_rdy;
        logic             exp_busy;
        logic [1:0]       exp_sel;
        logic [3:0]       exp_ov;
    } vec_t;

    typedef struct {
        logic [1:0]       ch;
        logic [WIDTH-1:0] data;
    } sb_t;

    sb_t        sb[$];
    logic [1:0] m_next;
    int         n_pass;
    int         n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic iv, input logic [WIDTH-1:0] d,
                         input logic [3:0] ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        sb_t e;
        e.ch   = m_next;
        e.data = d;
        sb.push_back(e);
        m_next = m_next + 2'd1;
    endtask

    // Wait for the sampling edge and score any delivery happening this cycle
    task automatic at_neg();
        sb_t e;
        @(negedge clk);
        if (!reset && bus.busy && bus.out_ready[bus.sel]) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_delivery: got ch%0d data %0h expected none", bus.sel, bus.out_data);
            end else begin
                e = sb.pop_front();
                chk("deliver_ch", 32'(bus.sel), 32'(e.ch));
                chk("deliver_data", 32'(bus.out_data), 32'(e.data));
                chk("deliver_onehot", 32'(bus.out_valid), 32'(4'b0001 << e.ch));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        sb.delete();
        m_next = 2'd0;
        reset  = 1'b1;
        drive(1'b1, 16'hEEEE, 4'b0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            at_neg();
            chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        reset = 1'b0;
        drive(1'b0, '0, 4'b0000, 1'b0);
        at_neg();
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_sel", 32'(bus.sel), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_out_data", 32'(bus.out_data), 32'd0);
        tick();
    endtask

    vec_t vec[8];

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_next  = 2'd0;
        reset   = 1'b1;
        drive(1'b0, '0, 4'b0000, 1'b0);

        // Strict rotation with all consumers ready: applied one record per cycle
        vec[0] = '{1'b1, 16'h00A0, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0000};
        vec[1] = '{1'b1, 16'h00A1, 4'hF, 1'b1, 1'b1, 2'd0, 4'b0001};
        vec[2] = '{1'b1, 16'h00A2, 4'hF, 1'b1, 1'b1, 2'd1, 4'b0010};
        vec[3] = '{1'b1, 16'h00A3, 4'hF, 1'b1, 1'b1, 2'd2, 4'b0100};
        vec[4] = '{1'b1, 16'h00A4, 4'hF, 1'b1, 1'b1, 2'd3, 4'b1000};
        vec[5] = '{1'b1, 16'h00A5, 4'hF, 1'b1, 1'b1, 2'd0, 4'b0001};
        vec[6] = '{1'b0, 16'h0000, 4'hF, 1'b1, 1'b1, 2'd1, 4'b0010};
        vec[7] = '{1'b0, 16'h0000, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0000};

        tick();
        do_reset();

        for (int i = 0; i < 8; i++) begin
            drive(vec[i].iv, vec[i].d, vec[i].ordy, 1'b0);
            at_neg();
            chk("rot_in_ready", 32'(bus.in_ready), 32'(vec[i].exp_rdy));
            chk("rot_busy", 32'(bus.busy), 32'(vec[i].exp_busy));
            chk("rot_out_valid", 32'(bus.out_valid), 32'(vec[i].exp_ov));
            if (vec[i].exp_busy) chk("rot_sel", 32'(bus.sel), 32'(vec[i].exp_sel));
            if (vec[i].iv && vec[i].exp_rdy) push_word(vec[i].d);
            tick();
        end

        // Backpressure: held word stays on ch0 while nobody is ready
        do_reset();
        drive(1'b1, 16'h0055, 4'b0000, 1'b0);
        at_neg();
        chk("bp_load_ready", 32'(bus.in_ready), 32'd1);
        push_word(16'h0055);
        tick();
        drive(1'b1, 16'h0056, 4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            at_neg();
            chk("bp_out_valid", 32'(bus.out_valid), 32'b0001);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_data", 32'(bus.out_data), 32'h0055);
            tick();
        end
        drive(1'b1, 16'h0056, 4'b0011, 1'b0);
        at_neg();
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        push_word(16'h0056);
        tick();
        drive(1'b0, '0, 4'b0010, 1'b0);
        at_neg();
        chk("bp_next_ch1", 32'(bus.out_valid), 32'b0010);
        tick();
        drive(1'b0, '0, 4'b0000, 1'b0);
        at_neg();
        chk("bp_drained", 32'(bus.busy), 32'd0);
        tick();

        // Flush: 0x77 held on ch2 is discarded; next word retargets ch2
        do_reset();
        drive(1'b1, 16'h0010, 4'hF, 1'b0); at_neg(); push_word(16'h0010); tick();
        drive(1'b1, 16'h0011, 4'hF, 1'b0); at_neg(); push_word(16'h0011); tick();
        drive(1'b1, 16'h0077, 4'hF, 1'b0); at_neg();
        chk("fl_load_ready", 32'(bus.in_ready), 32'd1);
        push_word(16'h0077); tick();
        drive(1'b0, '0, 4'b0000, 1'b0);
        at_neg();
        chk("fl_held_ch2", 32'(bus.out_valid), 32'b0100);
        tick();
        drive(1'b1, 16'h0088, 4'b0000, 1'b1);
        at_neg();
        chk("fl_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        void'(sb.pop_back());
        m_next = m_next - 2'd1;
        drive(1'b1, 16'h0099, 4'hF, 1'b0);
        at_neg();
        chk("fl_busy_after", 32'(bus.busy), 32'd0);
        chk("fl_ready_after", 32'(bus.in_ready), 32'd1);
        push_word(16'h0099);
        tick();
        drive(1'b0, '0, 4'hF, 1'b0);
        at_neg();
        chk("fl_next_ch2", 32'(bus.sel), 32'd2);
        tick();

        // Skip targeting: ptr=1, out_ready=1001 at load
        do_reset();
        drive(1'b1, 16'h00C0, 4'hF, 1'b0); at_neg(); push_word(16'h00C0); tick();
        drive(1'b0, '0, 4'hF, 1'b0); at_neg(); tick();
        drive(1'b1, 16'h00C1, 4'b1001, 1'b0);
        at_neg();
        chk("skip_load_ready", 32'(bus.in_ready), 32'd1);
        sb.push_back('{SKIP_CH, 16'h00C1});
        tick();
        drive(1'b0, '0, 4'b0000, 1'b0);
        at_neg();
        chk("skip_sel", 32'(bus.sel), 32'(SKIP_CH));
        tick();
        drive(1'b0, '0, 4'hF, 1'b0); at_neg(); tick();

        // Skip targeting with no channel ready falls back to ptr
        do_reset();
        drive(1'b1, 16'h00C2, 4'hF, 1'b0); at_neg(); push_word(16'h00C2); tick();
        drive(1'b0, '0, 4'hF, 1'b0); at_neg(); tick();
        drive(1'b1, 16'h00C3, 4'b0000, 1'b0); at_neg(); push_word(16'h00C3); tick();
        drive(1'b0, '0, 4'b0000, 1'b0);
        at_neg();
        chk("skip_none_sel", 32'(bus.sel), 32'd1);
        tick();
        drive(1'b0, '0, 4'b0010, 1'b0); at_neg(); tick();

        // Reset while a word is held on ch3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(16'h00D0 + i), 4'hF, 1'b0);
            at_neg();
            push_word(16'(16'h00D0 + i));
            tick();
        end
        drive(1'b0, '0, 4'b0000, 1'b0);
        at_neg();
        chk("mid_held_ch3", 32'(bus.out_valid), 32'b1000);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        m_next = 2'd0;
        at_neg();
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_busy", 32'(bus.busy), 32'd0);
        tick();
        drive(1'b1, 16'h00E0, 4'hF, 1'b0); at_neg(); push_word(16'h00E0); tick();
        drive(1'b0, '0, 4'hF, 1'b0);
        at_neg();
        chk("mid_first_ch0", 32'(bus.sel), 32'd0);
        tick();

        drive(1'b0, '0, 4'b0000, 1'b0);
        at_neg();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
